// File: rtl/ysyx_22040127_pkg.sv
// Shared decode definitions for the IDU/EXU boundary: format codes, opcodes and
// the opcode-to-format classifier.
package ysyx_22040127_pkg;

  typedef enum logic [2:0] {
    TYPE_I = 3'd0,
    TYPE_U = 3'd1,
    TYPE_S = 3'd2,
    TYPE_J = 3'd3,
    TYPE_R = 3'd4,
    TYPE_B = 3'd5,
    TYPE_N = 3'd6,
    TYPE_X = 3'd7
  } inst_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // W-form opcodes only exist on RV64; anything unlisted classifies as TYPE_X.
  function automatic inst_type_e decode_type(input logic [31:0] inst, input logic rv64);
    inst_type_e t;
    t = TYPE_X;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OP_LUI, OP_AUIPC:          t = TYPE_U;
        OP_JAL:                    t = TYPE_J;
        OP_JALR, OP_LOAD, OP_IMM:  t = TYPE_I;
        OP_IMM32:                  t = rv64 ? TYPE_I : TYPE_X;
        OP_REG:                    t = TYPE_R;
        OP_REG32:                  t = rv64 ? TYPE_R : TYPE_X;
        OP_STORE:                  t = TYPE_S;
        OP_BRANCH:                 t = TYPE_B;
        OP_SYSTEM, OP_FENCE:       t = TYPE_N;
        default:                   t = TYPE_X;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/ysyx_22040127_idu_pipe_immgen.sv
// Immediate generator: assembles the 32-bit immediate for the given format and
// sign-extends it to XLEN.
module ysyx_22040127_immgen
  import ysyx_22040127_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst_i,
  input  inst_type_e      type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (type_i)
      TYPE_I, TYPE_N: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      TYPE_S:         imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      TYPE_B:         imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                               inst_i[11:8], 1'b0};
      TYPE_U:         imm32 = {inst_i[31:12], 12'b0};
      TYPE_J:         imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                               inst_i[30:21], 1'b0};
      default:        imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_22040127_idu_pipe.sv
// Registered RV32I/RV64I decode stage: decodes the IFU word combinationally and
// holds the result in a single valid/ready pipeline register with flush.
module ysyx_22040127_idu_pipe
  import ysyx_22040127_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_wen,
  output logic            out_rs1_ren,
  output logic            out_rs2_ren,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic RV64 = (XLEN == 64);

  inst_type_e      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_wen, dec_rs1_ren, dec_rs2_ren;
  logic            accept;

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  inst_type_e      type_q, type_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            rd_wen_q, rd_wen_d, rs1_ren_q, rs1_ren_d, rs2_ren_q, rs2_ren_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            illegal_q, illegal_d;

  ysyx_22040127_immgen #(.XLEN(XLEN)) u_immgen (
    .inst_i (in_inst),
    .type_i (dec_type),
    .imm_o  (dec_imm)
  );

  always_comb begin
    dec_type    = decode_type(in_inst, RV64);
    dec_rd_wen  = (dec_type inside {TYPE_I, TYPE_U, TYPE_J, TYPE_R}) && (in_inst[11:7] != 5'd0);
    dec_rs1_ren = dec_type inside {TYPE_I, TYPE_S, TYPE_B, TYPE_R};
    dec_rs2_ren = dec_type inside {TYPE_S, TYPE_B, TYPE_R};
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Bundle fields only change on accept, so a stalled bundle stays stable.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    type_d    = type_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_wen_d  = rd_wen_q;
    rs1_ren_d = rs1_ren_q;
    rs2_ren_d = rs2_ren_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      type_d    = dec_type;
      rd_d      = in_inst[11:7];
      rs1_d     = in_inst[19:15];
      rs2_d     = in_inst[24:20];
      rd_wen_d  = dec_rd_wen;
      rs1_ren_d = dec_rs1_ren;
      rs2_ren_d = dec_rs2_ren;
      imm_d     = dec_imm;
      illegal_d = (dec_type == TYPE_X);
    end else if (flush || out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      type_q    <= TYPE_I;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_wen_q  <= 1'b0;
      rs1_ren_q <= 1'b0;
      rs2_ren_q <= 1'b0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      type_q    <= type_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_wen_q  <= rd_wen_d;
      rs1_ren_q <= rs1_ren_d;
      rs2_ren_q <= rs2_ren_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_type    = type_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd_wen  = rd_wen_q;
  assign out_rs1_ren = rs1_ren_q;
  assign out_rs2_ren = rs2_ren_q;
  assign out_imm     = imm_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_ysyx_22040127_idu_pipe.sv
// Directed bench for the decode stage: an RV64 and an RV32 instance share the
// same stimulus; decode vectors are table-driven, handshake corners hand-written.
module tb_ysyx_22040127_idu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;

  logic        in_ready, out_valid, out_rd_wen, out_rs1_ren, out_rs2_ren, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [2:0]  out_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        in_ready32, out_valid32, out_rd_wen32, out_rs1_ren32, out_rs2_ren32, out_illegal32;
  logic [31:0] out_pc32, out_imm32;
  logic [2:0]  out_type32;
  logic [4:0]  out_rd32, out_rs132, out_rs232;

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic        sb_en;
  logic [63:0] sb_next;

  always #5 clk = ~clk;
  assign in_pc32 = in_pc[31:0];

  ysyx_22040127_idu_pipe #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_type(out_type), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd_wen(out_rd_wen), .out_rs1_ren(out_rs1_ren),
    .out_rs2_ren(out_rs2_ren), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  ysyx_22040127_idu_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_type(out_type32), .out_rd(out_rd32), .out_rs1(out_rs132),
    .out_rs2(out_rs232), .out_rd_wen(out_rd_wen32), .out_rs1_ren(out_rs1_ren32),
    .out_rs2_ren(out_rs2_ren32), .out_imm(out_imm32), .out_illegal(out_illegal32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  t64;
    logic        wen, r1, r2;
    logic [63:0] imm64;
    logic        ill64;
    logic [2:0]  t32;
    logic [31:0] imm32;
    logic        ill32;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle from negedge to negedge; the handshake model runs alongside.
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic ordy, input logic fl, output logic acc);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", {63'b0, in_ready}, {63'b0, !m_valid || ordy});
    chk("in_ready32", {63'b0, in_ready32}, {63'b0, !m_valid || ordy});
    if (sb_en && m_valid && ordy) begin
      chk("scoreboard_pc", out_pc, sb_next);
      sb_next = sb_next + 64'd4;
    end
    acc = v && (!m_valid || ordy) && !fl;
    if (acc) begin
      m_valid = 1'b1; m_pc = pc; m_inst = inst;
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
    chk("out_valid32", {63'b0, out_valid32}, {63'b0, m_valid});
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_pc32", {32'b0, out_pc32}, {32'b0, m_pc[31:0]});
      chk("out_rd", {59'b0, out_rd}, {59'b0, m_inst[11:7]});
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_pc"}, out_pc, 64'd0);
    chk({tag, "_type"}, {61'b0, out_type}, 64'd0);
    chk({tag, "_rd"}, {59'b0, out_rd}, 64'd0);
    chk({tag, "_en"}, {61'b0, out_rd_wen, out_rs1_ren, out_rs2_ren}, 64'd0);
    chk({tag, "_imm"}, out_imm, 64'd0);
    chk({tag, "_illegal"}, {63'b0, out_illegal}, 64'd0);
    chk({tag, "_valid32"}, {63'b0, out_valid32}, 64'd0);
    chk({tag, "_imm32"}, {32'b0, out_imm32}, 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [63:0] pc;
    logic        e1, e2, e3;

    //           inst          rd  rs1 rs2 t64  wen r1 r2 imm64                  ill t32  imm32         ill32
    vecs[0]  = '{32'hFFF00093, 1,  0,  31, 3'd0, 1, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 3'd0, 32'hFFFFFFFF, 0};
    vecs[1]  = '{32'h0020B423, 8,  1,  2,  3'd2, 0, 1, 1, 64'h8,                0, 3'd2, 32'h8,        0};
    vecs[2]  = '{32'hFE000EE3, 29, 0,  0,  3'd5, 0, 1, 1, 64'hFFFFFFFFFFFFFFFC, 0, 3'd5, 32'hFFFFFFFC, 0};
    vecs[3]  = '{32'h800002B7, 5,  0,  0,  3'd1, 1, 0, 0, 64'hFFFFFFFF80000000, 0, 3'd1, 32'h80000000, 0};
    vecs[4]  = '{32'h0000006F, 0,  0,  0,  3'd3, 0, 0, 0, 64'h0,                0, 3'd3, 32'h0,        0};
    vecs[5]  = '{32'h0010809B, 1,  1,  1,  3'd0, 1, 1, 0, 64'h1,                0, 3'd7, 32'h0,        1};
    vecs[6]  = '{32'h00000000, 0,  0,  0,  3'd7, 0, 0, 0, 64'h0,                1, 3'd7, 32'h0,        1};
    vecs[7]  = '{32'h002081B3, 3,  1,  2,  3'd4, 1, 1, 1, 64'h0,                0, 3'd4, 32'h0,        0};
    vecs[8]  = '{32'h30200073, 0,  0,  2,  3'd6, 0, 0, 0, 64'h302,              0, 3'd6, 32'h302,      0};
    vecs[9]  = '{32'h002080BB, 1,  1,  2,  3'd4, 1, 1, 1, 64'h0,                0, 3'd7, 32'h0,        1};
    vecs[10] = '{32'h0000A003, 0,  1,  0,  3'd0, 0, 1, 0, 64'h0,                0, 3'd0, 32'h0,        0};
    vecs[11] = '{32'h00000010, 0,  0,  0,  3'd7, 0, 0, 0, 64'h0,                1, 3'd7, 32'h0,        1};
    vecs[12] = '{32'hFF9FF0EF, 1,  31, 25, 3'd3, 1, 0, 0, 64'hFFFFFFFFFFFFFFF8, 0, 3'd3, 32'hFFFFFFF8, 0};
    vecs[13] = '{32'h00001517, 10, 0,  0,  3'd1, 1, 0, 0, 64'h1000,             0, 3'd1, 32'h1000,     0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    m_valid = 1'b0; m_pc = '0; m_inst = '0; sb_en = 1'b0; sb_next = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, streamed back to back with the EXU always ready.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, vecs[i].inst, 64'h1000 + 64'(i) * 4, 1'b1, 1'b0, acc);
      chk($sformatf("v%0d_type", i), {61'b0, out_type}, {61'b0, vecs[i].t64});
      chk($sformatf("v%0d_rs1", i), {59'b0, out_rs1}, {59'b0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2", i), {59'b0, out_rs2}, {59'b0, vecs[i].rs2});
      chk($sformatf("v%0d_rdfield", i), {59'b0, out_rd}, {59'b0, vecs[i].rd});
      chk($sformatf("v%0d_en", i), {61'b0, out_rd_wen, out_rs1_ren, out_rs2_ren},
          {61'b0, vecs[i].wen, vecs[i].r1, vecs[i].r2});
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm64);
      chk($sformatf("v%0d_illegal", i), {63'b0, out_illegal}, {63'b0, vecs[i].ill64});
      e1 = vecs[i].ill32 ? 1'b0 : vecs[i].wen;
      e2 = vecs[i].ill32 ? 1'b0 : vecs[i].r1;
      e3 = vecs[i].ill32 ? 1'b0 : vecs[i].r2;
      chk($sformatf("v%0d_type32", i), {61'b0, out_type32}, {61'b0, vecs[i].t32});
      chk($sformatf("v%0d_en32", i), {61'b0, out_rd_wen32, out_rs1_ren32, out_rs2_ren32},
          {61'b0, e1, e2, e3});
      chk($sformatf("v%0d_imm32", i), {32'b0, out_imm32}, {32'b0, vecs[i].imm32});
      chk($sformatf("v%0d_illegal32", i), {63'b0, out_illegal32}, {63'b0, vecs[i].ill32});
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Stall for 5 cycles with a word pending, then release into a gapped stream.
    sb_en = 1'b1; sb_next = 64'h2000;
    step(1'b1, 32'hFFF00093, 64'h2000, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h002081B3, 64'h2004, 1'b0, 1'b0, acc);
      chk("stall_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("stall_type", {61'b0, out_type}, 64'd0);
      chk("stall_rd", {59'b0, out_rd}, 64'd1);
    end
    pc = 64'h2004;
    for (int i = 0; i < 12; i++) begin
      step((i % 4) != 3, 32'h002081B3, pc, (i % 3) != 2, 1'b0, acc);
      if (acc) pc = pc + 64'd4;
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    chk("stream_drained", sb_next, pc);
    sb_en = 1'b0;

    // Flush beats a simultaneous accept, both with and without a held bundle.
    step(1'b1, 32'h0020B423, 64'h3000, 1'b0, 1'b0, acc);
    step(1'b1, 32'h002081B3, 64'h3004, 1'b1, 1'b1, acc);
    step(1'b1, 32'h002081B3, 64'h3008, 1'b1, 1'b1, acc);
    step(1'b1, 32'h002081B3, 64'h300C, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Reset during a stall drops the held bundle and clears every output.
    step(1'b1, 32'h800002B7, 64'h4000, 1'b0, 1'b0, acc);
    step(1'b1, 32'hFFF00093, 64'h4004, 1'b0, 1'b0, acc);
    chk("prereset_imm", out_imm, 64'hFFFFFFFF80000000);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_zero("stall_rst");
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; m_valid = 1'b0;
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, acc);
    step(1'b1, 32'hFE000EE3, 64'h5000, 1'b1, 1'b0, acc);
    chk("post_rst_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
